// File: rtl/output_line_arbiter_if.sv
// Byte-source handshake bundle: three request/byte pairs in, a one-hot ack pulse back.
// The master side is the boards (keyboard, wordboard, tweetboard); the slave side is the arbiter.
interface output_line_arbiter_if;
    logic [2:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] ack;

    modport master (
        output req,
        output data0,
        output data1,
        output data2,
        input  ack
    );

    modport slave (
        input  req,
        input  data0,
        input  data1,
        input  data2,
        output ack
    );
endinterface

// File: rtl/output_line_arbiter.sv
// Round-robin grant of three byte sources onto one UART-style serial line; ack is the grant cycle, start bit follows it.
// Build option PARITY_EN inserts an even-parity bit between data and stop (frame 11 bits instead of 10).
module output_line_arbiter #(
    parameter int BIT_TICKS  = 868,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                  sysclk,
    input  logic                  reset,
    output_line_arbiter_if.slave  src,
    input  logic                  lock,
    input  logic [1:0]            lock_sel,
    output logic                  out_line,
    output logic                  busy,
    output logic [3:0]            LEDs
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      byte_q, byte_d;
    logic [1:0]      grant_q, grant_d;
    logic            line_q, line_d;
    logic            busy_q, busy_d;
    logic [3:0]      led_q, led_d;

    logic [2:0]      eligible;
    logic [2:0]      cand;
    logic [1:0]      rr1, rr2;
    logic            win_vld;
    logic [1:0]      win_idx;
    logic            tick_last;
    logic [2:0]      ack_c;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] n;
        case (idx)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Search order after the last grant: +1, +2, then the last grantee itself.
    always_comb begin
        eligible = lock ? onehot3(lock_sel) : 3'b111;
        cand     = src.req & eligible;
        rr1      = rr_next(grant_q);
        rr2      = rr_next(rr1);
        win_vld  = 1'b0;
        win_idx  = grant_q;
        if (cand[rr1]) begin
            win_vld = 1'b1;
            win_idx = rr1;
        end else if (cand[rr2]) begin
            win_vld = 1'b1;
            win_idx = rr2;
        end else if (cand[grant_q]) begin
            win_vld = 1'b1;
            win_idx = grant_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        grant_d   = grant_q;
        ack_c     = 3'b000;
        tick_last = (tick_q == TICK_LAST);

        if (state_q != ST_IDLE) begin
            tick_d = tick_last ? '0 : tick_q + TICK_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    case (win_idx)
                        2'd0:    byte_d = src.data0;
                        2'd1:    byte_d = src.data1;
                        default: byte_d = src.data2;
                    endcase
                    grant_d = win_idx;
                    ack_c   = reset ? 3'b000 : onehot3(win_idx);
                    tick_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick_last) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_last) begin
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (tick_last) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so the line changes exactly on bit boundaries.
    always_comb begin
        line_d = IDLE_LEVEL;
        case (state_d)
            ST_START:  line_d = ~IDLE_LEVEL;
            ST_DATA:   line_d = byte_d[bit_d];
`ifdef PARITY_EN
            ST_PARITY: line_d = ^byte_d;
`endif
            default:   line_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE);
        led_d  = {lock, busy_d ? onehot3(grant_d) : 3'b000};
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 8'h00;
            grant_q <= 2'd2;
            line_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            led_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            grant_q <= grant_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign src.ack  = ack_c;
    assign out_line = line_q;
    assign busy     = busy_q;
    assign LEDs     = led_q;

endmodule

// File: tb/tb_output_line_arbiter.sv
// Randomised and directed bench for output_line_arbiter against a frame-level reference model.
module tb_output_line_arbiter;
    localparam int BT = 4;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       lock;
    logic [1:0] lock_sel;
    logic       out_line;
    logic       busy;
    logic [3:0] LEDs;

    output_line_arbiter_if ifc();

    output_line_arbiter #(.BIT_TICKS(BT), .IDLE_LEVEL(1'b1)) dut (
        .sysclk   (clk),
        .reset    (reset),
        .src      (ifc.slave),
        .lock     (lock),
        .lock_sel (lock_sel),
        .out_line (out_line),
        .busy     (busy),
        .LEDs     (LEDs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame-level state advanced once per cycle.
    logic       valid = 1'b0;
    int         rem = 0;
    int         fpos = 0;
    logic       fbits [NB];
    int         m_last = 2;
    logic [2:0] m_oh = 3'b000;
    logic       m_led3 = 1'b0;
    int         run = 0;
    bit         aborted = 0;

    always @(negedge clk) begin
        logic       e_line;
        logic       e_busy;
        logic [3:0] e_led;
        logic [2:0] e_ack;
        int         w;
        logic [7:0] b;
        if (valid) begin
            w = -1;
            e_ack = 3'b000;
            if (rem > 0) begin
                e_line = fbits[fpos / BT];
                e_busy = 1'b1;
                e_led  = {m_led3, m_oh};
            end else begin
                e_line = 1'b1;
                e_busy = 1'b0;
                e_led  = {m_led3, 3'b000};
                if (!reset) begin
                    for (int k = 3; k >= 1; k--) begin
                        int s;
                        s = (m_last + k) % 3;
                        if (ifc.req[s] && (!lock || int'(lock_sel) == s)) w = s;
                    end
                    if (w >= 0) e_ack = 3'b001 << w;
                end
            end
            check("out_line", 32'(out_line), 32'(e_line));
            check("busy", 32'(busy), 32'(e_busy));
            check("LEDs", 32'(LEDs), 32'(e_led));
            check("ack", 32'(ifc.ack), 32'(e_ack));

            if (busy === 1'b1) begin
                run++;
                if (reset) aborted = 1;
            end else if (run > 0) begin
                if (!aborted) check("busy_len", run, NB * BT);
                run = 0;
                aborted = 0;
            end

            if (reset) begin
                rem = 0;
                m_last = 2;
                m_led3 = 1'b0;
                m_oh = 3'b000;
            end else begin
                m_led3 = lock;
                if (rem > 0) begin
                    rem--;
                    fpos++;
                end else if (w >= 0) begin
                    b = (w == 0) ? ifc.data0 : (w == 1) ? ifc.data1 : ifc.data2;
                    fbits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) fbits[1 + i] = b[i];
`ifdef PARITY_EN
                    fbits[9] = ^b;
`endif
                    fbits[NB - 1] = 1'b1;
                    rem = NB * BT;
                    fpos = 0;
                    m_last = w;
                    m_oh = 3'b001 << w;
                end
            end
        end else if (reset === 1'b1) begin
            valid = 1'b1;
            rem = 0;
            m_last = 2;
            m_led3 = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifc.ack != 3'b000) seen = 1;
        end
        if (!seen) check("ack_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        lock = 1'b0;
        lock_sel = 2'd0;
        ifc.req = 3'b000;
        ifc.data0 = 8'h00;
        ifc.data1 = 8'h00;
        ifc.data2 = 8'h00;
        step(2);
        reset = 1'b0;
        step(20);

        // Single byte from source 0.
        ifc.data0 = 8'hA5;
        ifc.req = 3'b001;
        step(1);
        ifc.req = 3'b000;
        step(50);

        // All three requesting: rotation 0,1,2,0.
        ifc.data0 = 8'h00;
        ifc.req = 3'b111;
        step(4 * (NB * BT + 1) + 2);
        ifc.req = 3'b000;
        step(50);

        // Lock to source 2 while only 0 and 1 request.
        lock = 1'b1;
        lock_sel = 2'd2;
        ifc.req = 3'b011;
        step(50);
        ifc.req = 3'b111;
        step(NB * BT + 10);
        ifc.req = 3'b000;
        lock = 1'b0;
        step(20);

        // Reset pulse during data bit 3.
        ifc.req = 3'b111;
        ifc.data0 = 8'h3C;
        wait_ack();
        step(BT + 3 * BT);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(3 * (NB * BT + 1));
        ifc.req = 3'b000;
        step(10);

        // Single byte from source 1 with odd weight.
        ifc.data1 = 8'h07;
        ifc.req = 3'b010;
        step(1);
        ifc.req = 3'b000;
        step(NB * BT + 10);

        // Random traffic.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 15) == 0) ifc.req = 3'($urandom);
            if ($urandom_range(0, 3) == 0) ifc.data0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ifc.data1 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ifc.data2 = 8'($urandom);
            if ($urandom_range(0, 80) == 0) lock = ~lock;
            if ($urandom_range(0, 40) == 0) lock_sel = 2'($urandom);
            reset = ($urandom_range(0, 700) == 0);
            step(1);
        end
        reset = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
